// File: rtl/if_stage.sv
// Instruction fetch stage: PC, BOOT/RUN/HALT control and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to build the saturating fetch/stall performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0004,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] read_add,
    input  logic [31:0] instruction,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        valid_next;
    logic [31:0] instr_next;
    logic [31:0] idpc_next;
    logic        misalign_next;

    assign read_add = pc;
    assign halted   = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            id_valid     <= 1'b0;
            id_instr     <= 32'h0;
            id_pc        <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            id_valid     <= valid_next;
            id_instr     <= instr_next;
            id_pc        <= idpc_next;
            misalign_err <= misalign_next;
        end
    end

    // A redirect outranks everything else; a misaligned one parks the stage in HALT.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        valid_next    = id_valid;
        instr_next    = id_instr;
        idpc_next     = id_pc;
        misalign_next = misalign_err;
        case (state)
            BOOT: state_next = RUN;
            RUN, HALT: begin
                if (br_taken) begin
                    valid_next = 1'b0;
                    if (br_target[1:0] == 2'b00) begin
                        pc_next    = br_target;
                        state_next = RUN;
                    end else begin
                        misalign_next = 1'b1;
                        state_next    = HALT;
                    end
                end else if (state == RUN) begin
                    if (!id_valid || id_ready) begin
                        instr_next = instruction;
                        idpc_next  = pc;
                        valid_next = 1'b1;
                        if (instruction == HALT_INSTR) begin
                            state_next = HALT;
                        end else begin
                            pc_next = pc + 32'd4;
                        end
                    end
                end else if (id_valid && id_ready) begin
                    valid_next = 1'b0;
                end
            end
            default: state_next = BOOT;
        endcase
    end

`ifdef IF_PERF_CNT_EN
    logic capture;
    logic stall;

    assign capture = (state == RUN) && !br_taken && (!id_valid || id_ready);
    assign stall   = (state == RUN) && !br_taken && id_valid && !id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (capture && (fetch_cnt != 32'hFFFF_FFFF)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign fetch_cnt = 32'h0;
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized redirects,
// stalls and resets, all compared against a behavioural model of the fetch stage.
module tb_if_stage;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_0004;
    localparam logic [31:0] HALT_W   = 32'h0000_0073;
    localparam logic [31:0] W_ADD    = 32'h0020_81B3;
    localparam logic [31:0] W_SUB    = 32'h4020_81B3;
    localparam logic [31:0] W_AND    = 32'h0020_F1B3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] read_add, instruction, br_target, id_instr, id_pc, fetch_cnt, stall_cnt;
    logic        br_taken = 1'b0, id_ready = 1'b0, id_valid, halted, misalign_err;

    logic [31:0] read_add2, instruction2, id_instr2, id_pc2, fetch_cnt2, stall_cnt2;
    logic        id_valid2, halted2, misalign_err2;
    logic        one = 1'b1, zero = 1'b0;
    logic [31:0] zero32 = 32'h0;

    logic [31:0] mem [64];

    assign instruction  = mem[read_add[7:2]];
    assign instruction2 = mem[read_add2[7:2]];

    if_stage dut (
        .clk(clk), .rst(rst), .read_add(read_add), .instruction(instruction),
        .br_taken(br_taken), .br_target(br_target), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .halted(halted),
        .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .read_add(read_add2), .instruction(instruction2),
        .br_taken(zero), .br_target(zero32), .id_ready(one),
        .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .halted(halted2),
        .misalign_err(misalign_err2), .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = boot, 1 = run, 2 = halt.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_idpc, m_fetch, m_stall;
    logic        m_valid, m_mis;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_mode = 0; m_pc = RESET_PC; m_valid = 0; m_instr = 0; m_idpc = 0;
        m_mis = 0; m_fetch = 0; m_stall = 0;
    endtask

    task automatic modelStep();
        logic [31:0] word;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (br_taken) begin
            m_valid = 0;
            if (br_target % 4 == 0) begin
                m_pc = br_target;
                m_mode = 1;
            end else begin
                m_mis = 1;
                m_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (m_valid && !id_ready) begin
                if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            end else begin
                word = mem[(m_pc / 4) % 64];
                m_instr = word;
                m_idpc = m_pc;
                m_valid = 1;
                if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
                if (word == HALT_W) m_mode = 2;
                else m_pc = m_pc + 4;
            end
        end else if (m_valid && id_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".read_add"}, read_add, m_pc);
        checkOutput({where, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
        checkOutput({where, ".id_instr"}, id_instr, m_instr);
        checkOutput({where, ".id_pc"}, id_pc, m_idpc);
        checkOutput({where, ".halted"}, {31'b0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
        checkOutput({where, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_mis});
        checkOutput({where, ".fetch_cnt"}, fetch_cnt, PERF_EN ? m_fetch : 32'h0);
        checkOutput({where, ".stall_cnt"}, stall_cnt, PERF_EN ? m_stall : 32'h0);
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge with rst low.
    task automatic doReset();
        rst = 1'b1; br_taken = 1'b0; id_ready = 1'b0; br_target = 32'h0;
        #1;
        modelReset();
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks after the rising edge.
    task automatic applyStimulus(input logic rdy, input logic br, input logic [31:0] tgt);
        id_ready = rdy; br_taken = br; br_target = tgt;
        modelStep();
        @(posedge clk);
        #1;
        checkAll("cycle");
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < 64; i++) begin
            mem[i] = {$urandom} | 32'h0000_0100;
        end
        mem[1] = W_ADD; mem[2] = W_SUB; mem[3] = W_AND; mem[4] = HALT_W;
        br_target = 32'h0;

        @(negedge clk);
        doReset();
        applyStimulus(1, 0, 0);
        checkOutput("boot.no_capture", {31'b0, id_valid}, 32'd0);
        applyStimulus(1, 0, 0);
        checkOutput("c2.id_pc", id_pc, 32'd4);
        checkOutput("c2.id_instr", id_instr, W_ADD);
        checkOutput("wrap.first_pc", id_pc2, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0);
        checkOutput("c3.id_pc", id_pc, 32'd8);
        checkOutput("wrap.second_pc", id_pc2, 32'h0000_0000);
        applyStimulus(1, 0, 0);
        checkOutput("c4.id_pc", id_pc, 32'd12);
        checkOutput("c4.id_instr", id_instr, W_AND);
        applyStimulus(1, 0, 0);
        checkOutput("halt.id_instr", id_instr, HALT_W);
        checkOutput("halt.halted", {31'b0, halted}, 32'd1);
        applyStimulus(1, 0, 0);
        checkOutput("halt.read_add", read_add, 32'd16);
        applyStimulus(1, 1, 32'd4);
        checkOutput("resume.halted", {31'b0, halted}, 32'd0);
        checkOutput("resume.read_add", read_add, 32'd4);
        applyStimulus(1, 0, 0);
        checkOutput("resume.id_pc", id_pc, 32'd4);

        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("stall.id_pc", id_pc, 32'd4);
            checkOutput("stall.read_add", read_add, 32'd8);
        end
`ifdef IF_PERF_CNT_EN
        checkOutput("stall.stall_cnt", stall_cnt, 32'd3);
`endif
        applyStimulus(0, 1, 32'h2C);
        checkOutput("br.id_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("br.read_add", read_add, 32'h2C);
        applyStimulus(1, 0, 0);
        checkOutput("br.id_pc", id_pc, 32'h2C);

        applyStimulus(1, 1, 32'h6);
        checkOutput("mis.err", {31'b0, misalign_err}, 32'd1);
        checkOutput("mis.halted", {31'b0, halted}, 32'd1);
        checkOutput("mis.read_add", read_add, 32'h30);
        applyStimulus(0, 1, 32'h8);
        checkOutput("mis.sticky", {31'b0, misalign_err}, 32'd1);
        doReset();
        checkOutput("mis.rst_err", {31'b0, misalign_err}, 32'd0);
        checkOutput("mis.rst_halted", {31'b0, halted}, 32'd0);

        mem[20] = HALT_W; mem[41] = HALT_W;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                doReset();
            end else begin
                tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, tgt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
